// File: rtl/timer_ctrl.sv
// Kitchen-timer countdown controller: synchronizes the divided clock into a one-cycle tick
// and sequences an MM:SS BCD countdown through keypad entry, start/stop, door and alarm.
module timer_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DONE_TICKS  = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clock_div100,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heater_on,
  output logic       paused,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned CntW = (DONE_TICKS < 2) ? 1 : $clog2(DONE_TICKS);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_last_q, sync_last_d;
  logic                   tick_q, tick_d;
  logic [CntW-1:0]        done_cnt_q, done_cnt_d;
  logic [3:0]             mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic                   heater_q, heater_d, paused_q, paused_d, done_q, done_d;

  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       count_zero, dec_zero;

  // Synchronizer plus rising-edge detector; the tick itself is registered.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], clock_div100};
    sync_last_d = sync_q[SYNC_STAGES-1];
    tick_d      = sync_q[SYNC_STAGES-1] & ~sync_last_q;
  end

  // One-second BCD decrement with borrow; seconds wrap to 59 regardless of entered form.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (!count_zero) begin
      if (so_q != 4'd0) begin
        dec_so = so_q - 4'd1;
      end else begin
        dec_so = 4'd9;
        if (st_q != 4'd0) begin
          dec_st = st_q - 4'd1;
        end else begin
          dec_st = 4'd5;
          if (mo_q != 4'd0) begin
            dec_mo = mo_q - 4'd1;
          end else begin
            dec_mo = 4'd9;
            dec_mt = mt_q - 4'd1;
          end
        end
      end
    end
  end

  assign count_zero = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign dec_zero   = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) &&
                      (dec_so == 4'd0);

  always_comb begin
    state_d    = state_q;
    done_cnt_d = done_cnt_q;
    mt_d       = mt_q;
    mo_d       = mo_q;
    st_d       = st_q;
    so_d       = so_q;
    unique case (state_q)
      StIdle: begin
        if (stop) begin
          {mt_d, mo_d, st_d, so_d} = 16'h0000;
        end else if (start) begin
          if (!count_zero && !door_open) state_d = StRun;
        end else if (digit_valid && (digit <= 4'd9)) begin
          {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, digit};
        end
      end
      StRun: begin
        if (stop || door_open) begin
          state_d = StPause;
        end else if (tick_q) begin
          {mt_d, mo_d, st_d, so_d} = {dec_mt, dec_mo, dec_st, dec_so};
          if (dec_zero) begin
            state_d    = StDone;
            done_cnt_d = '0;
          end
        end
      end
      StPause: begin
        if (stop) begin
          state_d                  = StIdle;
          {mt_d, mo_d, st_d, so_d} = 16'h0000;
        end else if (start && !door_open) begin
          state_d = StRun;
        end
      end
      StDone: begin
        {mt_d, mo_d, st_d, so_d} = 16'h0000;
        if (start || stop || digit_valid) begin
          state_d    = StIdle;
          done_cnt_d = '0;
        end else if (tick_q) begin
          if (done_cnt_q == CntW'(DONE_TICKS - 1)) begin
            state_d    = StIdle;
            done_cnt_d = '0;
          end else begin
            done_cnt_d = done_cnt_q + CntW'(1);
          end
        end
      end
    endcase
    heater_d = (state_d == StRun);
    paused_d = (state_d == StPause);
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      sync_last_q <= 1'b0;
      tick_q      <= 1'b0;
      done_cnt_q  <= '0;
      mt_q        <= 4'd0;
      mo_q        <= 4'd0;
      st_q        <= 4'd0;
      so_q        <= 4'd0;
      heater_q    <= 1'b0;
      paused_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      sync_last_q <= sync_last_d;
      tick_q      <= tick_d;
      done_cnt_q  <= done_cnt_d;
      mt_q        <= mt_d;
      mo_q        <= mo_d;
      st_q        <= st_d;
      so_q        <= so_d;
      heater_q    <= heater_d;
      paused_q    <= paused_d;
      done_q      <= done_d;
    end
  end

  assign min_tens  = mt_q;
  assign min_ones  = mo_q;
  assign sec_tens  = st_q;
  assign sec_ones  = so_q;
  assign heater_on = heater_q;
  assign paused    = paused_q;
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random strobes, checked every cycle against
// a model that treats the count as minutes/seconds integers.
module tb_timer_ctrl;
  localparam int unsigned SyncStages = 2;
  localparam int unsigned DoneTicks  = 3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       clock_div100 = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0, start = 1'b0, stop = 1'b0, door_open = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heater_on, paused, done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  timer_ctrl #(.SYNC_STAGES(SyncStages), .DONE_TICKS(DoneTicks)) dut (
    .clock(clock), .reset_n(reset_n), .clock_div100(clock_div100), .digit(digit),
    .digit_valid(digit_valid), .start(start), .stop(stop), .door_open(door_open),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .heater_on(heater_on), .paused(paused), .done(done), .state(state)
  );

  always #5 clock = ~clock;

  // Divided clock: 20-cycle square wave, changed away from the sampling edge.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clock);
      #2;
      cnt++;
      if (cnt == 10) begin
        cnt = 0;
        clock_div100 = ~clock_div100;
      end
    end
  end

  // Model: count as a 4-digit decimal N = minutes*100 + seconds.
  int m_n, m_st, m_dcnt;
  int hist[0:7];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_n = 0; m_st = 0; m_dcnt = 0;
      for (int i = 0; i < 8; i++) hist[i] = 0;
    end else begin
      int mins, secs;
      bit tick;
      // Raw edge sampled SyncStages+1 edges earlier takes effect now.
      tick = (hist[SyncStages] == 1) && (hist[SyncStages+1] == 0);
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(clock_div100);
      mins = m_n / 100;
      secs = m_n % 100;
      case (m_st)
        0: begin
          if (stop) m_n = 0;
          else if (start) begin
            if (m_n != 0 && !door_open) m_st = 1;
          end else if (digit_valid && digit <= 4'd9) m_n = (m_n * 10 + int'(digit)) % 10000;
        end
        1: begin
          if (stop || door_open) m_st = 2;
          else if (tick) begin
            if (secs > 0) secs--;
            else begin secs = 59; mins--; end
            m_n = mins * 100 + secs;
            if (m_n == 0) begin m_st = 3; m_dcnt = 0; end
          end
        end
        2: begin
          if (stop) begin m_st = 0; m_n = 0; end
          else if (start && !door_open) m_st = 1;
        end
        default: begin
          if (start || stop || digit_valid) m_st = 0;
          else if (tick) begin
            m_dcnt++;
            if (m_dcnt == DoneTicks) m_st = 0;
          end
        end
      endcase
    end
  end

  function automatic logic [20:0] model_out();
    int mins = m_n / 100;
    int secs = m_n % 100;
    model_out = {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10),
                 m_st == 1, m_st == 2, m_st == 3, 2'(m_st)};
  endfunction

  bit cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en && reset_n) begin
      logic [20:0] got;
      got = {min_tens, min_ones, sec_tens, sec_ones, heater_on, paused, done, state};
      total++;
      if (got !== model_out()) begin
        bad++;
        $display("FAIL cycle_model t=%0t got=%h exp=%h", $time, got, model_out());
      end
    end
  end

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
    digit_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask
  task automatic idle(input int n); repeat (n) cyc(); endtask
  task automatic key(input logic [3:0] d); digit = d; digit_valid = 1'b1; cyc(); endtask
  task automatic press_start(); start = 1'b1; cyc(); endtask
  task automatic press_stop(); stop = 1'b1; cyc(); endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin cyc(); n++; end
    check(name, 21'(state), 21'(s));
  endtask

  function automatic logic [20:0] digits();
    return 21'({min_tens, min_ones, sec_tens, sec_ones});
  endfunction

  initial begin
    #1;
    check("reset_outputs",
          {min_tens, min_ones, sec_tens, sec_ones, heater_on, paused, done, state}, 21'd0);
    #20;
    reset_n = 1'b1;
    cmp_en  = 1'b1;
    cyc();

    // 1: 00:05 counts down to done, alarm lasts three ticks.
    key(0); key(0); key(0); key(5);
    check("t1_entry", digits(), 21'h0005);
    press_start();
    check("t1_run", {20'd0, heater_on}, 21'd1);
    wait_state("t1_done", 2'd3, 5 * 20 + 40);
    check("t1_done_flags", {digits(), heater_on, done}, {16'h0000, 1'b0, 1'b1} << 0);
    wait_state("t1_back_idle", 2'd0, 3 * 20 + 40);
    check("t1_done_low", 21'(done), 21'd0);

    // 2: 01:00 -> 00:59, keypad ignored while running.
    key(1); key(0); key(0);
    press_start();
    begin
      int n = 0;
      while (sec_ones !== 4'd9 && n < 60) begin cyc(); n++; end
    end
    check("t2_borrow", digits(), 21'h0059);
    key(7);
    check("t2_key_in_run", digits(), 21'h0059);
    press_stop(); press_stop();

    // 3: door interlock.
    key(3); key(0);
    press_start();
    idle(5);
    door_open = 1'b1;
    cyc();
    check("t3_door_pause", 21'({paused, heater_on, state}), 21'({1'b1, 1'b0, 2'd2}));
    idle(45);
    press_start();
    check("t3_start_door_open", 21'(state), 21'd2);
    door_open = 1'b0;
    press_start();
    check("t3_resume", 21'(state), 21'd1);
    press_stop(); press_stop();

    // 4: cancel from pause; stop beats same-cycle digit and start.
    key(1); key(0);
    press_start();
    press_stop();
    check("t4_pause", 21'(state), 21'd2);
    press_stop();
    check("t4_cancel", {digits(), 3'b0, state}, 21'd0);
    key(9);
    stop = 1'b1; start = 1'b1; digit = 4'd9; digit_valid = 1'b1;
    cyc();
    check("t4_stop_wins", {digits(), 3'b0, state}, 21'd0);

    // 5: non-normalised 00:99 counts down through the tens; zero start and bad digit ignored.
    key(9); key(9);
    press_start();
    idle(10 * 20 + 10);
    press_stop(); press_stop();
    key(0); key(0); key(0);
    press_start();
    check("t5_zero_start", 21'(state), 21'd0);
    key(4'hA);
    check("t5_bad_digit", digits(), 21'd0);

    // 6: asynchronous reset mid-run.
    key(5);
    press_start();
    idle(7);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_reset",
          {min_tens, min_ones, sec_tens, sec_ones, heater_on, paused, done, state}, 21'd0);
    #17;
    reset_n = 1'b1;
    cyc();
    check("t6_idle_after", 21'(state), 21'd0);

    // Random strobes and door activity.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 99) < 2) door_open = ~door_open;
      if (r < 4) stop = 1'b1;
      else if (r < 12) start = 1'b1;
      else if (r < 30) begin
        digit = 4'($urandom_range(0, 15));
        digit_valid = 1'b1;
        if (r < 14) stop = 1'b1;
      end
      cyc();
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
